// File: rtl/fft_pkg.sv
// ---------------------------------------------------------------------------
// fft_pkg
// Shared constants, controller state encoding and the butterfly address
// generator for the 32-point radix-2 DIT in-place FFT sequencer.
//
// Contents:
//   N_LOG2, N, NBF, TW_AW  - transform geometry
//   AW, WR_W               - data memory address width, write delay-line width
//   fft_state_t            - controller states (IDLE, ISSUE, DRAIN, FIN)
//   bf_addr_t / bf_addr()  - operand and twiddle addresses for (stage, j)
// ---------------------------------------------------------------------------
package fft_pkg;

  localparam int N_LOG2 = 5;          // log2 of transform size = number of stages
  localparam int N      = 32;         // points per transform
  localparam int NBF    = 16;         // butterflies per stage (N/2)
  localparam int TW_AW  = 4;          // twiddle ROM index width (16 entries)
  localparam int AW     = N_LOG2;     // data memory address width
  localparam int WR_W   = 1 + 2 * AW; // {valid, addr_a, addr_b}

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } fft_state_t;

  typedef struct packed {
    logic [AW-1:0]    a;
    logic [AW-1:0]    b;
    logic [TW_AW-1:0] tw;
  } bf_addr_t;

  // For stage s the butterfly span is 2^s. The low s bits of j select the
  // position inside a group, the remaining bits select the group. Moving the
  // group bits up by one leaves room for the span, which gives the upper
  // operand, and the position scaled by 2^(4-s) indexes W32^k in the ROM.
  function automatic bf_addr_t bf_addr(input logic [2:0] s, input logic [3:0] j);
    bf_addr_t      r;
    logic [AW-1:0] jj;
    logic [AW-1:0] mask;
    logic [AW-1:0] pos;
    jj   = {1'b0, j};
    mask = (5'd1 << s) - 5'd1;
    pos  = jj & mask;
    r.a  = ((jj & ~mask) << 1) | pos;
    r.b  = r.a + (5'd1 << s);
    r.tw = TW_AW'(pos << (3'd4 - s));
    return r;
  endfunction

endpackage

// File: rtl/fft_wr_delay.sv
// ---------------------------------------------------------------------------
// fft_wr_delay
// Fixed-depth shift register that turns the issue strobe and operand
// addresses into the in-place write-back strobe and addresses, DEPTH cycles
// later (the butterfly datapath latency).
//
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low clear of every stage
//   din    - {valid, addr_a, addr_b} at issue time
//   dout   - the same word DEPTH cycles later
// ---------------------------------------------------------------------------
module fft_wr_delay #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe [DEPTH];

  // NOTE: every stage is cleared on reset, unlike a RAM, because a stale
  // valid bit left in the pipe would fire a write-back after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= din;
      for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
    end
  end

  assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/fft_seq_ctrl.sv
// ---------------------------------------------------------------------------
// fft_seq_ctrl
// Address/strobe sequencer for a 32-point radix-2 DIT in-place FFT whose
// input already sits bit-reversed in memory. Runs 5 stages of 16 butterflies,
// one issue per cycle, with BF_LAT drain cycles after each stage so a stage
// never reads a location before the previous stage has written it back.
//
// Parameters:
//   BF_LAT    - butterfly latency from issue to write-back, 1..4
// Ports:
//   clk       - clock, rising edge
//   rst_n     - asynchronous active-low reset, aborts any transform
//   start     - request a transform, honoured only in IDLE
//   busy      - first issue cycle through last write-back cycle
//   done      - one-cycle pulse after the final write-back
//   stage     - current issue stage 0..4
//   bf_valid  - butterfly read/issue strobe
//   rd_addr_a - lower operand address (0 when bf_valid is low)
//   rd_addr_b - upper operand address (0 when bf_valid is low)
//   tw_addr   - twiddle ROM index (0 when bf_valid is low)
//   wr_en     - write-back strobe, bf_valid delayed BF_LAT cycles
//   wr_addr_a - write-back address, rd_addr_a delayed BF_LAT cycles
//   wr_addr_b - write-back address, rd_addr_b delayed BF_LAT cycles
// ---------------------------------------------------------------------------
module fft_seq_ctrl
  import fft_pkg::*;
#(
  parameter int BF_LAT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             busy,
  output logic             done,
  output logic [2:0]       stage,
  output logic             bf_valid,
  output logic [AW-1:0]    rd_addr_a,
  output logic [AW-1:0]    rd_addr_b,
  output logic [TW_AW-1:0] tw_addr,
  output logic             wr_en,
  output logic [AW-1:0]    wr_addr_a,
  output logic [AW-1:0]    wr_addr_b
);

  fft_state_t  state;
  logic [3:0]  j;        // butterfly index within the current stage
  logic [1:0]  lat_cnt;  // drain cycles elapsed, 0..BF_LAT-1
  logic [WR_W-1:0] wr_word;

  // Outputs are registered: each branch loads the values for the cycle that
  // follows the edge, so the addresses always line up with bf_valid.
  // NOTE: non-blocking assignments throughout, so every branch reads the
  // pre-edge values of stage and j regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      stage     <= '0;
      j         <= '0;
      lat_cnt   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bf_valid  <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_addr   <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            state    <= ISSUE;
            stage    <= '0;
            j        <= '0;
            busy     <= 1'b1;
            bf_valid <= 1'b1;
            {rd_addr_a, rd_addr_b, tw_addr} <= bf_addr(3'd0, 4'd0);
          end
        end

        ISSUE: begin
          if (j == 4'(NBF - 1)) begin
            state    <= DRAIN;
            j        <= '0;
            lat_cnt  <= '0;
            bf_valid <= 1'b0;
            {rd_addr_a, rd_addr_b, tw_addr} <= '0;
          end else begin
            j <= j + 4'd1;
            {rd_addr_a, rd_addr_b, tw_addr} <= bf_addr(stage, j + 4'd1);
          end
        end

        // Hold off the next stage until the last write-back of this one.
        DRAIN: begin
          if (lat_cnt == 2'(BF_LAT - 1)) begin
            if (stage == 3'(N_LOG2 - 1)) begin
              state <= FIN;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state    <= ISSUE;
              stage    <= stage + 3'd1;
              bf_valid <= 1'b1;
              {rd_addr_a, rd_addr_b, tw_addr} <= bf_addr(stage + 3'd1, 4'd0);
            end
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end

        // done is high for this single cycle; start is deliberately not
        // looked at here so a request coincident with done is dropped.
        FIN: begin
          state <= IDLE;
          stage <= '0;
        end

        default: state <= IDLE;
      endcase
    end
  end

  fft_wr_delay #(
    .WIDTH (WR_W),
    .DEPTH (BF_LAT)
  ) u_wr_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .din   ({bf_valid, rd_addr_a, rd_addr_b}),
    .dout  (wr_word)
  );

  assign {wr_en, wr_addr_a, wr_addr_b} = wr_word;

endmodule

// File: tb/tb_fft_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_fft_seq_ctrl
// Three controllers (BF_LAT = 1, 2, 4) share clk, rst_n and start. A
// reference model predicts every output from the number of cycles since the
// accepted start, using the stage/butterfly schedule and address arithmetic
// of the radix-2 DIT algorithm. Includes directed spot values, stray starts
// (mid-run and on the done cycle), an async reset at T+40 and random runs.
// ---------------------------------------------------------------------------
module tb_fft_seq_ctrl;

  localparam int NDUT = 3;
  localparam int LAT [NDUT] = '{1, 2, 4};

  logic clk = 1'b0;
  logic rst_n;
  logic start;

  logic [NDUT-1:0]      busy, done, bfv, wen;
  logic [NDUT-1:0][2:0] stg;
  logic [NDUT-1:0][4:0] rda, rdb, wra, wrb;
  logic [NDUT-1:0][3:0] tw;

  always #5 clk = ~clk;

  fft_seq_ctrl #(.BF_LAT(1)) dut_l1 (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy[0]), .done(done[0]),
    .stage(stg[0]), .bf_valid(bfv[0]), .rd_addr_a(rda[0]), .rd_addr_b(rdb[0]),
    .tw_addr(tw[0]), .wr_en(wen[0]), .wr_addr_a(wra[0]), .wr_addr_b(wrb[0]));

  fft_seq_ctrl #(.BF_LAT(2)) dut_l2 (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy[1]), .done(done[1]),
    .stage(stg[1]), .bf_valid(bfv[1]), .rd_addr_a(rda[1]), .rd_addr_b(rdb[1]),
    .tw_addr(tw[1]), .wr_en(wen[1]), .wr_addr_a(wra[1]), .wr_addr_b(wrb[1]));

  fft_seq_ctrl #(.BF_LAT(4)) dut_l4 (
    .clk(clk), .rst_n(rst_n), .start(start), .busy(busy[2]), .done(done[2]),
    .stage(stg[2]), .bf_valid(bfv[2]), .rd_addr_a(rda[2]), .rd_addr_b(rdb[2]),
    .tw_addr(tw[2]), .wr_en(wen[2]), .wr_addr_a(wra[2]), .wr_addr_b(wrb[2]));

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int t0   [NDUT];   // cycle in which the running transform's start was accepted, -1 if none
  int wcnt [NDUT];   // write-back pulses seen in the current run

  typedef struct {
    int v, stg, a, b, tw, we, wa, wb, busy, done;
  } exp_t;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Which butterfly (stage s, index j) is issued d cycles after start, or -1.
  function automatic int issue_idx(input int L, input int d, output int s);
    s = 0;
    for (int k = 0; k < 5; k++) begin
      int off = d - 1 - k * (16 + L);
      if (off >= 0 && off < 16) begin
        s = k;
        return off;
      end
    end
    return -1;
  endfunction

  function automatic void addrs(input int s, input int j, output int a, output int b, output int t);
    int span = 2 ** s;
    int pos  = j % span;
    int grp  = j / span;
    a = grp * 2 * span + pos;
    b = a + span;
    t = pos * (16 / span);
  endfunction

  function automatic exp_t model(input int L, input int d);
    exp_t e;
    int   s, j, t;
    e = '{default: 0};
    if (d >= 1 && d <= 81 + 5 * L)
      for (int k = 0; k < 5; k++) if (d - 1 - k * (16 + L) >= 0) e.stg = k;
    j = issue_idx(L, d, s);
    if (j >= 0) begin
      e.v = 1;
      addrs(s, j, e.a, e.b, e.tw);
    end
    j = issue_idx(L, d - L, s);
    if (j >= 0) begin
      e.we = 1;
      addrs(s, j, e.wa, e.wb, t);
    end
    e.busy = (d >= 1 && d <= 80 + 5 * L) ? 1 : 0;
    e.done = (d == 81 + 5 * L) ? 1 : 0;
    return e;
  endfunction

  task automatic check_all();
    for (int i = 0; i < NDUT; i++) begin
      int    L = LAT[i];
      int    d = (t0[i] < 0) ? -1000 : cyc - t0[i];
      exp_t  e = model(L, d);
      string p = $sformatf("L%0d d%0d", L, d);
      check({p, " bf_valid"}, 32'(bfv[i]),  e.v);
      check({p, " stage"},    32'(stg[i]),  e.stg);
      check({p, " rd_a"},     32'(rda[i]),  e.a);
      check({p, " rd_b"},     32'(rdb[i]),  e.b);
      check({p, " tw"},       32'(tw[i]),   e.tw);
      check({p, " wr_en"},    32'(wen[i]),  e.we);
      check({p, " wr_a"},     32'(wra[i]),  e.wa);
      check({p, " wr_b"},     32'(wrb[i]),  e.wb);
      check({p, " busy"},     32'(busy[i]), e.busy);
      check({p, " done"},     32'(done[i]), e.done);
      if (t0[i] >= 0) begin
        if (wen[i] === 1'b1) wcnt[i]++;
        if (d == 81 + 5 * L) check({p, " wr_count"}, wcnt[i], 80);
      end
      // Directed values for the BF_LAT=2 controller.
      if (i == 1 && t0[i] >= 0) begin
        case (d)
          1:  begin check("s0j0 rd_a", 32'(rda[1]), 0);  check("s0j0 rd_b", 32'(rdb[1]), 1);
                    check("s0j0 tw", 32'(tw[1]), 0);     check("s0j0 stage", 32'(stg[1]), 0); end
          3:  begin check("wb0 wr_en", 32'(wen[1]), 1);  check("wb0 wr_a", 32'(wra[1]), 0);
                    check("wb0 wr_b", 32'(wrb[1]), 1); end
          20: begin check("s1j1 rd_a", 32'(rda[1]), 1);  check("s1j1 rd_b", 32'(rdb[1]), 3);
                    check("s1j1 tw", 32'(tw[1]), 8); end
          42: begin check("s2j5 rd_a", 32'(rda[1]), 9);  check("s2j5 rd_b", 32'(rdb[1]), 13);
                    check("s2j5 tw", 32'(tw[1]), 4); end
          88: begin check("s4j15 rd_a", 32'(rda[1]), 15); check("s4j15 rd_b", 32'(rdb[1]), 31);
                    check("s4j15 tw", 32'(tw[1]), 15); end
          90: begin check("last busy", 32'(busy[1]), 1); check("early done", 32'(done[1]), 0); end
          91: check("done T+91", 32'(done[1]), 1);
          default: ;
        endcase
      end
    end
  endtask

  // One clock cycle: check this cycle's outputs, then drive start for it.
  task automatic step(input bit st);
    @(negedge clk);
    cyc++;
    check_all();
    start = st;
    if (rst_n && st)
      for (int i = 0; i < NDUT; i++)
        if (t0[i] < 0 || cyc - t0[i] >= 82 + 5 * LAT[i]) begin
          t0[i]   = cyc;
          wcnt[i] = 0;
        end
  endtask

  // Asynchronous reset in the middle of the current cycle.
  task automatic reset_now();
    rst_n = 1'b0;
    for (int i = 0; i < NDUT; i++) begin
      t0[i]   = -1;
      wcnt[i] = 0;
    end
    #1;
    check_all();
  endtask

  int tstart;

  initial begin
    start = 1'b0;
    rst_n = 1'b1;
    for (int i = 0; i < NDUT; i++) begin
      t0[i]   = -1;
      wcnt[i] = 0;
    end
    #2;
    reset_now();
    repeat (3) step(1'b0);
    rst_n = 1'b1;

    // Directed run: stray starts at T+10 and on the BF_LAT=2 done cycle.
    repeat ($urandom_range(2, 5)) step(1'b0);
    step(1'b1);
    tstart = cyc;
    for (int d = 1; d <= 110; d++) step(d == 10 || d == 91);
    repeat (120) step(1'b0);

    // Reset during stage 2, then a clean run.
    step(1'b1);
    repeat (40) step(1'b0);
    reset_now();
    repeat (3) step(1'b0);
    rst_n = 1'b1;
    repeat (2) step(1'b0);
    step(1'b1);
    repeat (130) step(1'b0);

    // Random runs with stray starts and occasional resets.
    for (int r = 0; r < 5; r++) begin
      int len = $urandom_range(90, 130);
      int rst_at = ($urandom % 3 == 0) ? $urandom_range(5, 85) : -1;
      repeat ($urandom_range(1, 8)) step(1'b0);
      step(1'b1);
      for (int k = 0; k < len; k++) begin
        if (k == rst_at) begin
          reset_now();
          repeat ($urandom_range(1, 3)) step(1'b0);
          rst_n = 1'b1;
        end
        step(($urandom % 12) == 0);
      end
    end
    repeat (110) step(1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
